// File: rtl/led_pwm_core.sv
// PWM LED driver with optional blinking, fed by shadow copies of the AXI4-Lite
// configuration registers that are reloaded only at PWM period boundaries.
module led_pwm_core #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [31:0]         ctrl_reg,
  input  logic [31:0]         duty_reg,
  input  logic [31:0]         prescale_reg,
  input  logic [31:0]         blink_reg,
  input  logic                cfg_wr,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                period_tick,
  output logic                cfg_busy
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  state_t              state, state_nxt;
  logic [11:0]         sh_ctrl;
  logic [31:0]         sh_duty;
  logic [15:0]         sh_pre;
  logic [15:0]         sh_blink;
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         blk_cnt;
  logic                phase;

  logic                en;
  logic [NUM_LEDS-1:0] mask;
  logic [NUM_LEDS-1:0] force_on;
  logic                tick;
  logic                pend;
  logic                load;
  logic [NUM_LEDS-1:0] led_nxt;

  // Register bits that carry no function in this core.
  logic unused_bits;
  assign unused_bits = ^{ctrl_reg[31:12], prescale_reg[31:16], blink_reg[31:16],
                         sh_duty, sh_ctrl};

  assign en       = sh_ctrl[0];
  assign mask     = sh_ctrl[4 +: NUM_LEDS];
  assign force_on = sh_ctrl[8 +: NUM_LEDS];
  assign tick     = en && (pre_cnt == sh_pre);
  assign pend     = tick && (pwm_cnt == PWM_MAX);
  assign cfg_busy = (state == PEND);

  // A write while disabled loads at once; otherwise it waits for the period
  // end, and a write landing on the period end itself loads on that edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    load      = 1'b0;
    state_nxt = state;
    if (cfg_wr && !en) begin
      load = 1'b1;
    end else if (pend && (cfg_wr || state == PEND)) begin
      load = 1'b1;
    end else if (cfg_wr) begin
      state_nxt = PEND;
    end
    if (load) state_nxt = IDLE;
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_nxt[i] = en & mask[i] & phase &
                   (force_on[i] | (pwm_cnt < sh_duty[8*i +: PWM_BITS]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      sh_ctrl     <= '0;
      sh_duty     <= '0;
      sh_pre      <= '0;
      sh_blink    <= '0;
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blk_cnt     <= '0;
      phase       <= 1'b1;
      led_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      led_out     <= led_nxt;
      period_tick <= pend;
      if (load) begin
        sh_ctrl  <= ctrl_reg[11:0];
        sh_duty  <= duty_reg;
        sh_pre   <= prescale_reg[15:0];
        sh_blink <= blink_reg[15:0];
        pre_cnt  <= '0;
        pwm_cnt  <= '0;
        blk_cnt  <= '0;
        phase    <= 1'b1;
      end else if (!en) begin
        pre_cnt <= '0;
        pwm_cnt <= '0;
        blk_cnt <= '0;
        phase   <= 1'b1;
      end else begin
        if (tick) begin
          pre_cnt <= '0;
          pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
        if (sh_blink == 16'd0) begin
          blk_cnt <= '0;
          phase   <= 1'b1;
        end else if (pend) begin
          if (blk_cnt == sh_blink - 16'd1) begin
            blk_cnt <= '0;
            phase   <= ~phase;
          end else begin
            blk_cnt <= blk_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_core.sv
// Directed bench for led_pwm_core: high-time counts per PWM period window,
// deferred and coincident updates, blink, force-on and asynchronous reset.
module tb_led_pwm_core;

  localparam int NUM_LEDS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         ctrl_reg = '0;
  logic [31:0]         duty_reg = '0;
  logic [31:0]         prescale_reg = '0;
  logic [31:0]         blink_reg = '0;
  logic                cfg_wr = 1'b0;
  logic [NUM_LEDS-1:0] led_out;
  logic                period_tick;
  logic                cfg_busy;

  int n_checks = 0;
  int n_errors = 0;

  int   c_led [NUM_LEDS];
  int   c_tick;
  int   c_busy;
  logic last_tick;
  logic [31:0] st_ctrl, st_duty, st_pre, st_blink;

  always #5 clk = ~clk;

  led_pwm_core #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(8)) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .ctrl_reg    (ctrl_reg),
    .duty_reg    (duty_reg),
    .prescale_reg(prescale_reg),
    .blink_reg   (blink_reg),
    .cfg_wr      (cfg_wr),
    .led_out     (led_out),
    .period_tick (period_tick),
    .cfg_busy    (cfg_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stage(input logic [31:0] c, input logic [31:0] d,
                       input logic [31:0] p, input logic [31:0] b);
    st_ctrl = c; st_duty = d; st_pre = p; st_blink = b;
  endtask

  // Drive the staged config with a one-cycle cfg_wr, starting at a negedge.
  task automatic write_cfg();
    @(negedge clk);
    ctrl_reg = st_ctrl; duty_reg = st_duty; prescale_reg = st_pre; blink_reg = st_blink;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (period_tick) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Accumulate outputs over the next len negedges; optionally pulse the staged
  // write at sample wr_at (0 = no write).
  task automatic measure(input int len, input int wr_at);
    for (int k = 0; k < NUM_LEDS; k++) c_led[k] = 0;
    c_tick = 0;
    c_busy = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_LEDS; k++) c_led[k] += int'(led_out[k]);
      c_tick += int'(period_tick);
      c_busy += int'(cfg_busy);
      if (wr_at != 0 && i == wr_at) begin
        ctrl_reg = st_ctrl; duty_reg = st_duty; prescale_reg = st_pre; blink_reg = st_blink;
        cfg_wr = 1'b1;
      end else if (wr_at != 0 && i == wr_at + 1) begin
        cfg_wr = 1'b0;
      end
    end
    last_tick = period_tick;
  endtask

  task automatic check_window(input string tag, input int e0, input int e1,
                              input int e2, input int e3, input int ebusy);
    check({tag, "_led0"}, 32'(c_led[0]), 32'(e0));
    check({tag, "_led1"}, 32'(c_led[1]), 32'(e1));
    check({tag, "_led2"}, 32'(c_led[2]), 32'(e2));
    check({tag, "_led3"}, 32'(c_led[3]), 32'(e3));
    check({tag, "_ticks"}, 32'(c_tick), 32'd1);
    check({tag, "_tick_last"}, 32'(last_tick), 32'd1);
    check({tag, "_busy"}, 32'(c_busy), 32'(ebusy));
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_led", 32'(led_out), 32'd0);

    // 1: immediate load, LED0 at 64/256
    stage(32'h0000_00F1, 32'h0000_0040, 32'd0, 32'd0);
    write_cfg();
    check("imm_first", 32'(led_out), 32'd0);
    check("imm_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    check("imm_second", 32'(led_out), 32'd1);
    wait_tick("t1_align");
    measure(256, 0);
    check_window("t1a", 64, 0, 0, 0, 0);
    measure(256, 0);
    check_window("t1b", 64, 0, 0, 0, 0);

    // 2: deferred update issued at pwm_cnt = 10
    stage(32'h0000_00F1, 32'h0000_00C0, 32'd0, 32'd0);
    measure(256, 10);
    check_window("t2_old", 64, 0, 0, 0, 245);
    check("t2_busy_end", 32'(cfg_busy), 32'd0);
    measure(256, 0);
    check_window("t2_new", 192, 0, 0, 0, 0);

    // 3: prescale 1, blink 2 periods on / 2 off
    stage(32'h0000_0011, 32'h0000_00FF, 32'd1, 32'd2);
    write_cfg();
    wait_tick("t3_align");
    measure(512, 0);
    check_window("t3_p0", 510, 0, 0, 0, 0);
    measure(512, 0);
    check_window("t3_p1", 510, 0, 0, 0, 0);
    measure(512, 0);
    check_window("t3_p2", 0, 0, 0, 0, 0);
    measure(512, 0);
    check_window("t3_p3", 0, 0, 0, 0, 0);
    measure(512, 0);
    check_window("t3_p4", 510, 0, 0, 0, 0);

    // 4: force-on with mask
    stage(32'h0000_0331, 32'h0000_0000, 32'd0, 32'd0);
    write_cfg();
    wait_tick("t4_align");
    measure(256, 0);
    check_window("t4", 256, 256, 0, 0, 0);

    // 5: write coincident with the period end
    stage(32'h0000_0031, 32'h0000_8020, 32'd0, 32'd0);
    measure(256, 255);
    check_window("t5_old", 256, 256, 0, 0, 0);
    check("t5_busy_end", 32'(cfg_busy), 32'd0);
    measure(256, 0);
    check_window("t5_new", 32, 128, 0, 0, 0);

    // 6: reset while an update is pending
    stage(32'h0000_00F1, 32'h0000_00FF, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    ctrl_reg = st_ctrl; duty_reg = st_duty; prescale_reg = st_pre; blink_reg = st_blink;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("t6_busy_pre", 32'(cfg_busy), 32'd1);
    check("t6_led_pre", 32'(led_out), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_led", 32'(led_out), 32'd0);
    check("t6_async_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c_tick = 0;
    c_busy = 0;
    c_led[0] = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      c_tick += int'(period_tick);
      c_busy += int'(cfg_busy);
      c_led[0] += int'(led_out != '0);
    end
    check("t6_no_led", 32'(c_led[0]), 32'd0);
    check("t6_no_tick", 32'(c_tick), 32'd0);
    check("t6_no_busy", 32'(c_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
